frame_config_sequencer: RTL and testbench

FRAME_CONFIG_SEQUENCER -- requirements
Module: frame_config_sequencer

---
 rtl/frame_config_sequencer.sv | 126 ++++++++++++
 tb/tb_frame_config_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_config_sequencer.sv
// Frame configuration sequencer: syncs onto a 32-bit bitstream, decodes frame
// headers and drives one registered frame word plus a one-hot latch strobe per frame.
module frame_config_sequencer #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32  // only 32 is supported
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       synced,
  output logic                       busy,
  output logic                       error,
  output logic [15:0]                frame_count
);

  localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
  localparam logic [31:0] DesyncWord = 32'hFAB0_FAB0;
  localparam logic [7:0]  HeaderTag  = 8'hA5;

  typedef enum logic [2:0] {
    ST_DESYNC,
    ST_HEADER,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [7:0]                 r_index;
  logic [FrameBitsPerRow-1:0] r_frame_data;
  logic                       r_error;
  logic [15:0]                r_frame_count;

  logic                       w_handshake;
  logic                       w_index_ok;
  logic                       w_load_index;
  logic                       w_load_data;
  logic                       w_set_error;
  logic [MaxFramesPerCol-1:0] w_strobe_onehot;

  assign s_ready     = (r_state == ST_DESYNC) || (r_state == ST_HEADER) || (r_state == ST_DATA);
  assign busy        = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
  assign synced      = (r_state != ST_DESYNC);
  assign error       = r_error;
  assign frame_count = r_frame_count;
  assign FrameData   = r_frame_data;

  assign w_handshake     = s_valid && s_ready;
  assign w_index_ok      = (32'(r_index) < MaxFramesPerCol);
  assign w_strobe_onehot = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_index;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load_index = 1'b0;
    w_load_data  = 1'b0;
    w_set_error  = 1'b0;
    unique case (r_state)
      ST_DESYNC: begin
        if (w_handshake && (s_data == SyncWord)) w_next_state = ST_HEADER;
      end
      ST_HEADER: begin
        if (w_handshake) begin
          if (s_data[31:24] == HeaderTag) begin
            w_next_state = ST_DATA;
            w_load_index = 1'b1;
          end else if (s_data == DesyncWord) begin
            w_next_state = ST_DESYNC;
          end else if (s_data != SyncWord) begin
            w_set_error = 1'b1;
          end
        end
      end
      ST_DATA: begin
        // The payload is never decoded; sync/desync patterns are plain data here.
        if (w_handshake) begin
          if (w_index_ok) begin
            w_next_state = ST_SETUP;
            w_load_data  = 1'b1;
          end else begin
            w_next_state = ST_HEADER;
            w_set_error  = 1'b1;
          end
        end
      end
      ST_SETUP:  w_next_state = ST_STROBE;
      ST_STROBE: w_next_state = ST_HOLD;
      ST_HOLD:   w_next_state = ST_HEADER;
      default:   w_next_state = ST_DESYNC;
    endcase
  end

  always_comb begin
    FrameStrobe = '0;
    if (r_state == ST_STROBE) FrameStrobe = w_strobe_onehot;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_DESYNC;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_index       <= '0;
      r_frame_data  <= '0;
      r_error       <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_load_index) r_index <= s_data[7:0];
      if (w_load_data)  r_frame_data <= s_data;
      if (w_set_error)  r_error <= 1'b1;
      if (r_state == ST_STROBE) r_frame_count <= r_frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: inputs change and outputs are
// sampled on the falling edge, with expected values worked out by hand.
module tb_frame_config_sequencer;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        synced;
  logic        busy;
  logic        error;
  logic [15:0] frame_count;

  int passed = 0;
  int total  = 0;

  int mon_en        = 0;
  int strobe_cycles = 0;
  int bad_onehot    = 0;

  frame_config_sequencer #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .synced     (synced),
    .busy       (busy),
    .error      (error),
    .frame_count(frame_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en != 0) begin
      if (FrameStrobe != '0) strobe_cycles++;
      if (!$onehot0(FrameStrobe)) bad_onehot++;
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send_word(input logic [31:0] w);
    int waited;
    waited  = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!s_ready) begin
      total++;
      $display("FAIL send_timeout: s_ready stayed %b, want 1 for word %h", s_ready, w);
    end
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (FrameData !== 32'h0) $display("FAIL rst_data: got %h want %h", FrameData, 32'h0); else passed++;
    total++; if (FrameStrobe !== 20'h0) $display("FAIL rst_strobe: got %h want %h", FrameStrobe, 20'h0); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passed++;
    total++; if (frame_count !== 16'h0) $display("FAIL rst_count: got %0d want 0", frame_count); else passed++;
    total++; if (synced !== 1'b0) $display("FAIL rst_synced: got %b want 0", synced); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", s_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_word(32'hFAB0_FAB1);
    send_word(32'hA500_0003);
    send_word(32'h1234_5678);
    // SETUP
    total++; if (FrameData !== 32'h1234_5678) $display("FAIL b2b_setup_data: got %h want %h", FrameData, 32'h1234_5678); else passed++;
    total++; if (FrameStrobe !== 20'h0) $display("FAIL b2b_setup_strobe: got %h want %h", FrameStrobe, 20'h0); else passed++;
    total++; if (s_ready !== 1'b0) $display("FAIL b2b_setup_ready: got %b want 0", s_ready); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL b2b_setup_busy: got %b want 1", busy); else passed++;
    @(negedge CLK);  // STROBE
    total++; if (FrameStrobe !== 20'h00008) $display("FAIL b2b_strobe: got %h want %h", FrameStrobe, 20'h00008); else passed++;
    total++; if (s_ready !== 1'b0) $display("FAIL b2b_strobe_ready: got %b want 0", s_ready); else passed++;
    total++; if (frame_count !== 16'd0) $display("FAIL b2b_strobe_count: got %0d want 0", frame_count); else passed++;
    @(negedge CLK);  // HOLD
    total++; if (FrameStrobe !== 20'h0) $display("FAIL b2b_hold_strobe: got %h want %h", FrameStrobe, 20'h0); else passed++;
    total++; if (FrameData !== 32'h1234_5678) $display("FAIL b2b_hold_data: got %h want %h", FrameData, 32'h1234_5678); else passed++;
    total++; if (s_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b want 0", s_ready); else passed++;
    total++; if (frame_count !== 16'd1) $display("FAIL b2b_count: got %0d want 1", frame_count); else passed++;
    @(negedge CLK);  // HEADER
    total++; if (s_ready !== 1'b1) $display("FAIL b2b_header_ready: got %b want 1", s_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_header_busy: got %b want 0", busy); else passed++;
    total++; if (synced !== 1'b1) $display("FAIL b2b_synced: got %b want 1", synced); else passed++;
  endtask

  task automatic test_desync_discard();
    apply_reset();
    send_word(32'hDEAD_BEEF);
    total++; if (synced !== 1'b0) $display("FAIL dsc_synced_early: got %b want 0", synced); else passed++;
    total++; if (error !== 1'b0) $display("FAIL dsc_error_early: got %b want 0", error); else passed++;
    send_word(32'hFAB0_FAB1);
    total++; if (synced !== 1'b1) $display("FAIL dsc_synced: got %b want 1", synced); else passed++;
    total++; if (error !== 1'b0) $display("FAIL dsc_error: got %b want 0", error); else passed++;
  endtask

  // Continues from the synced state left by test_desync_discard.
  task automatic test_bad_index();
    send_word(32'hA500_0014);
    send_word(32'hCAFE_F00D);
    total++; if (error !== 1'b1) $display("FAIL bidx_error: got %b want 1", error); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL bidx_ready: got %b want 1", s_ready); else passed++;
    total++; if (FrameStrobe !== 20'h0) $display("FAIL bidx_strobe0: got %h want %h", FrameStrobe, 20'h0); else passed++;
    total++; if (FrameData !== 32'h0) $display("FAIL bidx_data: got %h want %h", FrameData, 32'h0); else passed++;
    @(negedge CLK);
    total++; if (FrameStrobe !== 20'h0) $display("FAIL bidx_strobe1: got %h want %h", FrameStrobe, 20'h0); else passed++;
    total++; if (frame_count !== 16'd0) $display("FAIL bidx_count: got %0d want 0", frame_count); else passed++;
    send_word(32'hA500_0013);
    send_word(32'h0BAD_F00D);
    @(negedge CLK);
    total++; if (FrameStrobe !== 20'h80000) $display("FAIL bidx_next_strobe: got %h want %h", FrameStrobe, 20'h80000); else passed++;
    @(negedge CLK);
    total++; if (frame_count !== 16'd1) $display("FAIL bidx_next_count: got %0d want 1", frame_count); else passed++;
    total++; if (error !== 1'b1) $display("FAIL bidx_sticky: got %b want 1", error); else passed++;
    @(negedge CLK);
  endtask

  task automatic test_header_error();
    apply_reset();
    send_word(32'hFAB0_FAB1);
    send_word(32'hFAB0_FAB1);  // resync while in HEADER
    total++; if (error !== 1'b0) $display("FAIL hdr_resync_error: got %b want 0", error); else passed++;
    total++; if (synced !== 1'b1) $display("FAIL hdr_resync_synced: got %b want 1", synced); else passed++;
    send_word(32'h1234_5678);
    total++; if (error !== 1'b1) $display("FAIL hdr_error: got %b want 1", error); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL hdr_stay_ready: got %b want 1", s_ready); else passed++;
    send_word(32'hA500_0001);
    send_word(32'h5555_AAAA);
    @(negedge CLK);
    total++; if (FrameStrobe !== 20'h00002) $display("FAIL hdr_after_strobe: got %h want %h", FrameStrobe, 20'h00002); else passed++;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_data_not_decoded();
    apply_reset();
    send_word(32'hFAB0_FAB1);
    send_word(32'hA500_0000);
    send_word(32'hFAB0_FAB0);
    total++; if (FrameData !== 32'hFAB0_FAB0) $display("FAIL raw_data: got %h want %h", FrameData, 32'hFAB0_FAB0); else passed++;
    total++; if (synced !== 1'b1) $display("FAIL raw_synced: got %b want 1", synced); else passed++;
    @(negedge CLK);
    total++; if (FrameStrobe !== 20'h00001) $display("FAIL raw_strobe: got %h want %h", FrameStrobe, 20'h00001); else passed++;
    repeat (2) @(negedge CLK);
    send_word(32'hFAB0_FAB0);
    total++; if (synced !== 1'b0) $display("FAIL raw_desync: got %b want 0", synced); else passed++;
    total++; if (error !== 1'b0) $display("FAIL raw_error: got %b want 0", error); else passed++;
  endtask

  task automatic test_reset_in_strobe();
    apply_reset();
    send_word(32'hFAB0_FAB1);
    send_word(32'hA500_0005);
    send_word(32'h7777_1111);
    @(negedge CLK);
    total++; if (FrameStrobe !== 20'h00020) $display("FAIL rsts_strobe: got %h want %h", FrameStrobe, 20'h00020); else passed++;
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    total++; if (FrameStrobe !== 20'h0) $display("FAIL rsts_strobe_clr: got %h want %h", FrameStrobe, 20'h0); else passed++;
    total++; if (frame_count !== 16'd0) $display("FAIL rsts_count: got %0d want 0", frame_count); else passed++;
    total++; if (synced !== 1'b0) $display("FAIL rsts_synced: got %b want 0", synced); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rsts_busy: got %b want 0", busy); else passed++;
    total++; if (FrameData !== 32'h0) $display("FAIL rsts_data: got %h want %h", FrameData, 32'h0); else passed++;
  endtask

  task automatic test_reset_precedence();
    apply_reset();
    reset   = 1'b1;
    s_data  = 32'hFAB0_FAB1;
    s_valid = 1'b1;
    @(negedge CLK);
    reset   = 1'b0;
    s_valid = 1'b0;
    @(negedge CLK);
    total++; if (synced !== 1'b0) $display("FAIL prec_synced: got %b want 0", synced); else passed++;
  endtask

  task automatic test_idle_hold();
    apply_reset();
    send_word(32'hFAB0_FAB1);
    send_word(32'hA500_0002);
    gap(8);
    total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", s_ready); else passed++;
    send_word(32'h0000_0042);
    @(negedge CLK);
    total++; if (FrameStrobe !== 20'h00004) $display("FAIL idle_strobe: got %h want %h", FrameStrobe, 20'h00004); else passed++;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_random_gaps();
    logic [31:0] payload;
    logic [19:0] exp_strobe;
    int          idx;
    apply_reset();
    strobe_cycles = 0;
    bad_onehot    = 0;
    mon_en        = 1;
    send_word(32'hFAB0_FAB1);
    for (int f = 0; f < 100; f++) begin
      idx        = $urandom_range(0, 19);
      payload    = $urandom;
      exp_strobe = 20'd1 << idx;
      gap($urandom_range(0, 3));
      send_word({24'hA5_0000, 8'(idx)});
      gap($urandom_range(0, 3));
      send_word(payload);
      total++; if (FrameData !== payload) $display("FAIL rnd_setup_data f%0d: got %h want %h", f, FrameData, payload); else passed++;
      @(negedge CLK);
      total++; if (FrameStrobe !== exp_strobe || FrameData !== payload) $display("FAIL rnd_strobe f%0d: got %h/%h want %h/%h", f, FrameStrobe, FrameData, exp_strobe, payload); else passed++;
      @(negedge CLK);
      total++; if (FrameData !== payload) $display("FAIL rnd_hold_data f%0d: got %h want %h", f, FrameData, payload); else passed++;
      @(negedge CLK);
    end
    mon_en = 0;
    total++; if (frame_count !== 16'd100) $display("FAIL rnd_count: got %0d want 100", frame_count); else passed++;
    total++; if (strobe_cycles != 100) $display("FAIL rnd_strobe_cycles: got %0d want 100", strobe_cycles); else passed++;
    total++; if (bad_onehot != 0) $display("FAIL rnd_onehot: got %0d want 0", bad_onehot); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rnd_error: got %b want 0", error); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_desync_discard();
    test_bad_index();
    test_header_error();
    test_data_not_decoded();
    test_reset_in_strobe();
    test_reset_precedence();
    test_idle_hold();
    test_random_gaps();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 2000000");
    $fatal(1);
  end

endmodule
